theia_mem_read_arbiter: RTL and testbench

- Shares THEIA's single external main-memory read port among the control processor and the four vector processors.
- Each requester presents a request and an address. The block grants one requester at a time, round-robin, with optional absolute priority for the control processor.
- It drives the external read handshake (oMEM_ReadRequest, oMemReadAddress, iMemDataAvailable, iMemReadData) and returns the read word to the granted requester.
- A watchdog guarantees forward progress if memory never answers.

---
 rtl/theia_mem_read_arbiter_pkg.sv | 26 ++
 rtl/theia_mem_read_arbiter_if.sv | 40 ++++
 rtl/theia_rr_pick.sv | 55 +++++
 rtl/theia_mem_read_arbiter.sv | 129 ++++++++++++
 tb/tb_theia_mem_read_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/theia_mem_read_arbiter_pkg.sv
// theia_mem_read_arbiter_pkg
//   Shared definitions for the main-memory read arbiter:
//   - FSM state encoding (IDLE / WAIT / RECOVER)
//   - requester index map (0 = control processor, 1..4 = VP0..VP3)
//   - default requester count and watchdog width
package theia_mem_read_arbiter_pkg;

  localparam int DEF_NUM_REQ = 5;

  // Requester slots on the shared read port.
  localparam int CP_IDX  = 0;
  localparam int VP0_IDX = 1;
  localparam int VP1_IDX = 2;
  localparam int VP2_IDX = 3;
  localparam int VP3_IDX = 4;

  // Watchdog counter width; TIMEOUT must fit in it (1..65535).
  localparam int WDOG_W = 16;

  typedef logic [1:0] arbState_t;

  localparam arbState_t ST_IDLE    = 2'd0;
  localparam arbState_t ST_WAIT    = 2'd1;
  localparam arbState_t ST_RECOVER = 2'd2;

endpackage

// File: rtl/theia_mem_read_arbiter_if.sv
// theia_mem_read_arbiter_if
//   Bundles the requester side and the external memory side of the read
//   arbiter.
//   Requester side : iReq, iReadAddress (in), oGrant, oReadData,
//                    oDataValid, oTimeout (out)
//   Memory side    : oMEM_ReadRequest, oMemReadAddress (out),
//                    iMemReadData, iMemDataAvailable (in)
//   Modport master = the arbiter; modport slave = requesters + memory.
interface theia_mem_read_arbiter_if
  import theia_mem_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ-1:0]        iReq;
  logic [NUM_REQ*ADDR_W-1:0] iReadAddress;
  logic [NUM_REQ-1:0]        oGrant;
  logic [DATA_W-1:0]         oReadData;
  logic [NUM_REQ-1:0]        oDataValid;
  logic                      oTimeout;
  logic                      oMEM_ReadRequest;
  logic [ADDR_W-1:0]         oMemReadAddress;
  logic [DATA_W-1:0]         iMemReadData;
  logic                      iMemDataAvailable;

  modport master (
    input  iReq, iReadAddress, iMemReadData, iMemDataAvailable,
    output oGrant, oReadData, oDataValid, oTimeout,
           oMEM_ReadRequest, oMemReadAddress
  );

  modport slave (
    output iReq, iReadAddress, iMemReadData, iMemDataAvailable,
    input  oGrant, oReadData, oDataValid, oTimeout,
           oMEM_ReadRequest, oMemReadAddress
  );

endinterface

// File: rtl/theia_rr_pick.sv
// theia_rr_pick
//   Combinational round-robin picker with optional absolute priority for
//   the control processor slot.
//   req     : request vector
//   ptr     : round-robin start index (always < NUM_REQ)
//   cp_prio : when set, a request on CP_IDX wins unconditionally
//   grant   : one-hot winner (all zero when nothing requests)
//   win     : binary index of the winner (0 when nothing requests)
module theia_rr_pick
  import theia_mem_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               cp_prio,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   win
);

  logic             found;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] cand;

  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;

    if (cp_prio && req[CP_IDX]) begin
      grant[CP_IDX] = 1'b1;
      win           = PTR_W'(CP_IDX);
      found         = 1'b1;
    end

    // Scan ptr, ptr+1, ... with wrap at NUM_REQ (not a power of two, so
    // the wrap is an explicit subtract rather than bit truncation).
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
        sum = sum - (PTR_W + 1)'(NUM_REQ);
      end
      cand = sum[PTR_W-1:0];
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        win         = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/theia_mem_read_arbiter.sv
// theia_mem_read_arbiter
//   Shares the single external main-memory read port between the control
//   processor (requester 0) and the four vector processors (1..4).
//   One read at a time: IDLE grants a winner and issues the request, WAIT
//   holds it until data (or the watchdog) ends it, RECOVER waits out the
//   trailing data-available cycle before the port is offered again.
//   Ports:
//     Clock : system clock, rising edge
//     Reset : asynchronous, active-low
//     bus   : theia_mem_read_arbiter_if.master (requester + memory signals)
module theia_mem_read_arbiter
  import theia_mem_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 255,
  parameter int CP_PRIORITY = 1
) (
  input logic                      Clock,
  input logic                      Reset,
  theia_mem_read_arbiter_if.master bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arbState_t           state;
  logic [PTR_W-1:0]    rrPtr;
  logic [WDOG_W-1:0]   watchdog;
  logic [NUM_REQ-1:0]  grantReg;
  logic [ADDR_W-1:0]   addrReg;
  logic                memReqReg;
  logic [DATA_W-1:0]   dataReg;
  logic [NUM_REQ-1:0]  validReg;
  logic                timeoutReg;

  logic [NUM_REQ-1:0]  pickGrant;
  logic [PTR_W-1:0]    pickIdx;
  logic [ADDR_W-1:0]   reqAddr [NUM_REQ];

  // Unpack the per-requester address slices.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gAddr
    assign reqAddr[gi] = bus.iReadAddress[gi*ADDR_W +: ADDR_W];
  end

  theia_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) uPick (
    .req     (bus.iReq),
    .ptr     (rrPtr),
    .cp_prio (CP_PRIORITY != 0),
    .grant   (pickGrant),
    .win     (pickIdx)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= ST_IDLE;
      rrPtr      <= '0;
      watchdog   <= '0;
      grantReg   <= '0;
      addrReg    <= '0;
      memReqReg  <= 1'b0;
      dataReg    <= '0;
      validReg   <= '0;
      timeoutReg <= 1'b0;
    end else begin
      // Completion strobes are single-cycle.
      validReg   <= '0;
      timeoutReg <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (|bus.iReq) begin
            grantReg  <= pickGrant;
            addrReg   <= reqAddr[pickIdx];
            memReqReg <= 1'b1;
            rrPtr     <= (pickIdx == PTR_W'(NUM_REQ - 1)) ? '0 : pickIdx + 1'b1;
            state     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          watchdog <= watchdog + 1'b1;
          if (bus.iMemDataAvailable) begin
            dataReg   <= bus.iMemReadData;
            validReg  <= grantReg;
            memReqReg <= 1'b0;
            state     <= ST_RECOVER;
          end else if (watchdog == WDOG_W'(TIMEOUT - 1)) begin
            // The counter reaches TIMEOUT on this edge: the request has
            // been held for exactly TIMEOUT cycles without an answer.
            dataReg    <= '0;
            validReg   <= grantReg;
            timeoutReg <= 1'b1;
            memReqReg  <= 1'b0;
            state      <= ST_RECOVER;
          end
        end

        ST_RECOVER: begin
          // Memory keeps data-available up one cycle after the request
          // drops; wait it out so it cannot complete the next grant.
          if (!bus.iMemDataAvailable) begin
            grantReg <= '0;
            watchdog <= '0;
            state    <= ST_IDLE;
          end
        end

        default: begin
          grantReg  <= '0;
          memReqReg <= 1'b0;
          watchdog  <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.oGrant           = grantReg;
  assign bus.oReadData        = dataReg;
  assign bus.oDataValid       = validReg;
  assign bus.oTimeout         = timeoutReg;
  assign bus.oMEM_ReadRequest = memReqReg;
  assign bus.oMemReadAddress  = addrReg;

endmodule

// File: tb/tb_theia_mem_read_arbiter.sv
// tb_theia_mem_read_arbiter
//   Directed bench: a table of single-read vectors followed by hand-written
//   multi-cycle sequences (round-robin, CP priority, watchdog abort,
//   trailing data-available, reset mid-WAIT).
module tb_theia_mem_read_arbiter;
  import theia_mem_read_arbiter_pkg::*;

  localparam int NR = DEF_NUM_REQ;
  localparam int AW = 32;
  localparam int DW = 32;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  theia_mem_read_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  theia_mem_read_arbiter #(
    .NUM_REQ     (NR),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT     (8),
    .CP_PRIORITY (1)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // ---------------- memory model ----------------
  logic memMute    = 1'b0;
  logic memStretch = 1'b0;
  logic memReqD1;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], 16'hC0DE};
  endfunction

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      bus.iMemDataAvailable <= 1'b0;
      bus.iMemReadData      <= '0;
      memReqD1              <= 1'b0;
    end else begin
      memReqD1              <= bus.oMEM_ReadRequest;
      bus.iMemDataAvailable <= !memMute &&
                               (bus.oMEM_ReadRequest || (memStretch && memReqD1));
      bus.iMemReadData      <= memWord(bus.oMemReadAddress);
    end
  end

  // ---------------- checking helpers ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic waitGrant();
    int w = 0;
    while (bus.oGrant == '0 && w < 30) begin tick(); w++; end
  endtask

  task automatic waitValid();
    int w = 0;
    while (bus.oDataValid == '0 && w < 30) begin tick(); w++; end
  endtask

  task automatic waitIdle();
    int w = 0;
    while (bus.oGrant != '0 && w < 30) begin tick(); w++; end
  endtask

  task automatic doReset();
    Reset      = 1'b0;
    bus.iReq   = '0;
    memMute    = 1'b0;
    memStretch = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [4:0]  req;
    logic [4:0]  expGrant;
    logic [31:0] expAddr;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs [8];

  // One full read: request, grant, 2-cycle memory answer, RECOVER, IDLE.
  task automatic runRow(input vec_t v, input int n);
    int w;
    bus.iReq = v.req;
    tick();
    check($sformatf("row%0d grant", n), 64'(bus.oGrant), 64'(v.expGrant));
    check($sformatf("row%0d addr", n), 64'(bus.oMemReadAddress), 64'(v.expAddr));
    check($sformatf("row%0d memreq", n), 64'(bus.oMEM_ReadRequest), 64'd1);
    check($sformatf("row%0d dv_early", n), 64'(bus.oDataValid), 64'd0);
    w = 0;
    while (bus.oDataValid == '0 && w < 20) begin tick(); w++; end
    check($sformatf("row%0d dv_latency", n), 64'(w), 64'd2);
    check($sformatf("row%0d dv", n), 64'(bus.oDataValid), 64'(v.expGrant));
    check($sformatf("row%0d data", n), 64'(bus.oReadData), 64'(v.expData));
    check($sformatf("row%0d timeout", n), 64'(bus.oTimeout), 64'd0);
    check($sformatf("row%0d memreq_drop", n), 64'(bus.oMEM_ReadRequest), 64'd0);
    bus.iReq = '0;
    tick();
    check($sformatf("row%0d dv_pulse", n), 64'(bus.oDataValid), 64'd0);
    check($sformatf("row%0d grant_hold", n), 64'(bus.oGrant), 64'(v.expGrant));
    tick();
    check($sformatf("row%0d grant_clear", n), 64'(bus.oGrant), 64'd0);
    $display("row %0d req=%b grant=%b addr=0x%0h data=0x%0h", n, v.req,
             v.expGrant, v.expAddr, v.expData);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t v;
    int   cnt;
    int   extraDv;
    logic [4:0] rrExp [5];

    // Requester addresses: CP=0x100, VP0..VP3 = 0x10,0x20,0x30,0x40.
    bus.iReadAddress = {32'h40, 32'h30, 32'h20, 32'h10, 32'h100};
    bus.iReq         = '0;

    // Sequence starts from rr_ptr=0 after reset; CP_PRIORITY=1.
    vecs[0] = '{req: 5'b00010, expGrant: 5'b00010, expAddr: 32'h10,  expData: 32'hDEADBEEF};
    vecs[1] = '{req: 5'b00110, expGrant: 5'b00100, expAddr: 32'h20,  expData: 32'h0020C0DE};
    vecs[2] = '{req: 5'b00011, expGrant: 5'b00001, expAddr: 32'h100, expData: 32'h0100C0DE};
    vecs[3] = '{req: 5'b10010, expGrant: 5'b00010, expAddr: 32'h10,  expData: 32'hDEADBEEF};
    vecs[4] = '{req: 5'b10001, expGrant: 5'b00001, expAddr: 32'h100, expData: 32'h0100C0DE};
    vecs[5] = '{req: 5'b10000, expGrant: 5'b10000, expAddr: 32'h40,  expData: 32'h0040C0DE};
    vecs[6] = '{req: 5'b11000, expGrant: 5'b01000, expAddr: 32'h30,  expData: 32'h0030C0DE};
    vecs[7] = '{req: 5'b01010, expGrant: 5'b00010, expAddr: 32'h10,  expData: 32'hDEADBEEF};

    // ---- reset state ----
    #2 Reset = 1'b0;
    #1;
    check("rst grant",  64'(bus.oGrant), 64'd0);
    check("rst dv",     64'(bus.oDataValid), 64'd0);
    check("rst tmo",    64'(bus.oTimeout), 64'd0);
    check("rst memreq", 64'(bus.oMEM_ReadRequest), 64'd0);
    check("rst addr",   64'(bus.oMemReadAddress), 64'd0);
    check("rst data",   64'(bus.oReadData), 64'd0);
    tick();
    tick();
    Reset = 1'b1;
    tick();

    // ---- table-driven single reads ----
    for (int i = 0; i < 8; i++) runRow(vecs[i], i);

    // ---- round-robin among VP0..VP3 (CP idle) ----
    doReset();
    rrExp[0] = 5'b00010; rrExp[1] = 5'b00100; rrExp[2] = 5'b01000;
    rrExp[3] = 5'b10000; rrExp[4] = 5'b00010;
    bus.iReq = 5'b11110;
    for (int k = 0; k < 5; k++) begin
      waitGrant();
      check($sformatf("rr%0d grant", k), 64'(bus.oGrant), 64'(rrExp[k]));
      waitValid();
      check($sformatf("rr%0d dv", k), 64'(bus.oDataValid), 64'(rrExp[k]));
      check($sformatf("rr%0d onehot", k), 64'($onehot(bus.oDataValid)), 64'd1);
      if (k == 4) bus.iReq = '0;
      waitIdle();
      $display("rr %0d grant=%b", k, rrExp[k]);
    end

    // ---- CP priority: CP arrives during VP1's WAIT ----
    doReset();
    bus.iReq = 5'b11100;
    waitGrant();
    check("cp first grant", 64'(bus.oGrant), 64'(5'b00100));
    tick();
    bus.iReq = 5'b11101;
    waitValid();
    check("cp vp1 dv", 64'(bus.oDataValid), 64'(5'b00100));
    bus.iReq = 5'b11001;
    waitIdle();
    waitGrant();
    check("cp grant", 64'(bus.oGrant), 64'(5'b00001));
    waitValid();
    check("cp dv", 64'(bus.oDataValid), 64'(5'b00001));
    check("cp data", 64'(bus.oReadData), 64'(32'h0100C0DE));
    bus.iReq = 5'b11000;
    waitIdle();
    waitGrant();
    check("cp then vp2", 64'(bus.oGrant), 64'(5'b01000));
    waitValid();
    bus.iReq = '0;
    waitIdle();
    $display("cp priority sequence grants=00100,00001,01000");

    // ---- watchdog abort with TIMEOUT=8 ----
    doReset();
    runRow(vecs[0], 100);
    memMute  = 1'b1;
    bus.iReq = 5'b01100;
    tick();
    check("to grant", 64'(bus.oGrant), 64'(5'b00100));
    cnt = 0;
    for (int w = 0; w < 40 && bus.oDataValid == '0; w++) begin
      if (bus.oMEM_ReadRequest) cnt++;
      tick();
    end
    check("to req_cycles", 64'(cnt), 64'd8);
    check("to dv", 64'(bus.oDataValid), 64'(5'b00100));
    check("to pulse", 64'(bus.oTimeout), 64'd1);
    check("to data", 64'(bus.oReadData), 64'd0);
    check("to memreq", 64'(bus.oMEM_ReadRequest), 64'd0);
    bus.iReq = 5'b01000;
    memMute  = 1'b0;
    tick();
    check("to pulse_end", 64'(bus.oTimeout), 64'd0);
    waitGrant();
    check("to next grant", 64'(bus.oGrant), 64'(5'b01000));
    waitValid();
    check("to next data", 64'(bus.oReadData), 64'(32'h0030C0DE));
    check("to next tmo", 64'(bus.oTimeout), 64'd0);
    bus.iReq = '0;
    waitIdle();
    $display("timeout sequence req_cycles=%0d", cnt);

    // ---- trailing data-available held one extra cycle ----
    doReset();
    memStretch = 1'b1;
    bus.iReq   = 5'b00110;
    waitGrant();
    check("tr grant", 64'(bus.oGrant), 64'(5'b00010));
    waitValid();
    check("tr dv", 64'(bus.oDataValid), 64'(5'b00010));
    bus.iReq = 5'b00100;
    cnt      = 0;
    extraDv  = 0;
    while (bus.oGrant != 5'b00100 && cnt < 20) begin
      tick();
      cnt++;
      if (bus.oDataValid != '0 && bus.oGrant != 5'b00100) extraDv++;
    end
    check("tr extra_dv", 64'(extraDv), 64'd0);
    check("tr gap", 64'(cnt), 64'd4);
    waitValid();
    check("tr next dv", 64'(bus.oDataValid), 64'(5'b00100));
    bus.iReq = '0;
    waitIdle();
    memStretch = 1'b0;
    $display("trailing sequence gap=%0d", cnt);

    // ---- reset mid-WAIT ----
    doReset();
    v = '{req: 5'b01000, expGrant: 5'b01000, expAddr: 32'h30, expData: 32'h0030C0DE};
    runRow(v, 200);
    bus.iReq = 5'b10010;
    tick();
    check("rw grant", 64'(bus.oGrant), 64'(5'b10000));
    check("rw memreq", 64'(bus.oMEM_ReadRequest), 64'd1);
    #2 Reset = 1'b0;
    #1;
    check("rw memreq_drop", 64'(bus.oMEM_ReadRequest), 64'd0);
    check("rw grant_clr", 64'(bus.oGrant), 64'd0);
    check("rw addr_clr", 64'(bus.oMemReadAddress), 64'd0);
    check("rw data_clr", 64'(bus.oReadData), 64'd0);
    tick();
    check("rw no_dv", 64'(bus.oDataValid), 64'd0);
    Reset = 1'b1;
    tick();
    check("rw rearb grant", 64'(bus.oGrant), 64'(5'b00010));
    check("rw rearb addr", 64'(bus.oMemReadAddress), 64'(32'h10));
    waitValid();
    check("rw dv", 64'(bus.oDataValid), 64'(5'b00010));
    check("rw data", 64'(bus.oReadData), 64'(32'hDEADBEEF));
    bus.iReq = '0;
    waitIdle();
    $display("reset-mid-wait sequence regrant=00010");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
